button_conditioner: RTL
=======================

# button_conditioner

Converts the three raw, active-low board push buttons (logic-0, logic-1, activity) into clean, single-cycle, active-high command pulses for the game controller. It sits directly upstream of the controller, between the board pins and its `logic0`/`logic1`/`activity`/`activity_reset` inputs. A short press of the activity button produces `activity`. A long hold produces `activity_reset` instead.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- `LONG_PRESS_CYCLES`, default 100000000: debounced hold time of the activity button that yields `activity_reset` (2 s).
- `CLOCK_50` input 1: the only clock, 50 MHz.
- `reset` input 1: asynchronous, active-high.
- `logic_0_button` input 1: raw pin, low = pressed, asynchronous to `CLOCK_50`.
- `logic_1_button` input 1: raw pin, low = pressed.
- `activity_button` input 1: raw pin, low = pressed.
- `logic0` output 1: one-cycle pulse on an accepted logic-0 press.
- `logic1` output 1: one-cycle pulse on an accepted logic-1 press.
- `activity` output 1: one-cycle pulse on release after a short activity press.
- `activity_reset` output 1: one-cycle pulse when an activity hold reaches `LONG_PRESS_CYCLES`.
- `held` output 3: debounced pressed levels, {activity, logic1, logic0}.

## Operation
- **Synchronizer:** each pin passes through a 2-FF synchronizer and is then inverted to pressed = 1.
- **Debouncer (per button):** holds a `stable` bit and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Sync value ≠ `stable`: counter increments.
  - Sync value = `stable`: counter clears.
  - Counter reaches `DEBOUNCE_CYCLES`: `stable` takes the sync value and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` is discarded.
- **Arming:** each button has an `armed` flag, cleared by reset. It sets only once `stable` = 0 has been observed after reset. No pulse is ever produced by an unarmed button, so a button held through reset produces nothing until it is released and pressed again.
- **Logic buttons:** on a `stable` 0→1 edge, the button's pulse is issued, subject to the rules below.
  - Mutual exclusion: while the other logic button's `stable` = 1, the press is ignored.
  - Same-cycle rising edges on both logic buttons: neither pulse is issued.
- **Activity FSM:** states IDLE, HOLD, LONG.
  - IDLE → HOLD on a debounced press of an armed button. The hold counter clears.
  - HOLD: the hold counter increments each cycle.
    - Debounced release: pulse `activity` and go to IDLE.
    - Counter reaches `LONG_PRESS_CYCLES`: pulse `activity_reset` and go to LONG.
  - LONG → IDLE on debounced release, with no `activity` pulse.
  - The hold counter has width $clog2(LONG_PRESS_CYCLES+1) and never wraps.
- The activity path is independent of the logic buttons; simultaneous pulses on different outputs are legal.
- **Reset values:** all outputs 0; `held` = 3'b000; all sync FFs, `stable`, counters and `armed` cleared; FSM in IDLE.
- **Reset asserted mid-hold:** state is lost; the next release produces no pulse.

## Timing
- All outputs are registered.
- **Press latency:** a raw pin edge, with the pin held steady afterwards, produces the output pulse exactly `DEBOUNCE_CYCLES`+3 rising edges later. The breakdown is:
  - 2 edges of synchronizer;
  - `DEBOUNCE_CYCLES` edges of counting;
  - 1 edge of output register.
- **`held` latency:** `held` changes `DEBOUNCE_CYCLES`+2 edges after the raw edge.
- **Pulse width:** every pulse is exactly 1 cycle. A new pulse on the same output requires a full debounced release and press in between.
- **`activity_reset` timing:** asserted `LONG_PRESS_CYCLES`+1 edges after `held[2]` rises.
- **Exact-threshold hold:** if the release is debounced on the same cycle the hold counter reaches `LONG_PRESS_CYCLES`, the long press wins: `activity_reset` is pulsed and `activity` is not.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- **Clean press:** `logic_0_button` low at edge 0 and held → `logic0` high only at edge 7; `held[0]`=1 from edge 6; on release, no further pulse.
- **Bounce:** `logic_1_button` toggles low/high with 3-cycle periods for 30 cycles, then stays high → `logic1` never asserts and `held[1]` stays 0.
- **Short/long activity:**
  - Press held 10 cycles after debounce, then released → exactly one `activity` pulse, occurring 7 edges after the release edge.
  - Press held 40 cycles → one `activity_reset` pulse 21 edges after `held[2]` rises; no `activity` pulse on release.
- **Logic conflict:**
  - Both logic buttons pressed on the same cycle → no pulses.
  - `logic_0_button` held, then `logic_1_button` pressed → only `logic0`.
- **Reset arming:** `activity_button` held low across a reset pulse → no output until release plus a fresh press, which then yields `activity` normally.
- **Mid-hold reset:** reset asserted during HOLD at cycle 12 → all outputs 0 immediately (asynchronous); release after reset → no pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Turns the three raw, active-low board push buttons into clean, single-cycle,
// active-high command pulses for the game controller. Each pin is
// synchronised, inverted to pressed = 1, and debounced. The logic buttons emit
// a pulse on an accepted press, provided the other logic button is not held.
// The activity button is timed by a small FSM. A short press yields `activity`
// on release. A long hold yields `activity_reset` once, and nothing on release.
//
// Parameters
//   DEBOUNCE_CYCLES   : consecutive disagreeing cycles needed to accept a level
//   LONG_PRESS_CYCLES : debounced hold time that turns a press into a reset
//
// Ports
//   CLOCK_50        in  : sole clock
//   reset           in  : asynchronous, active-high
//   logic_0_button  in  : raw pin, low = pressed, asynchronous to CLOCK_50
//   logic_1_button  in  : raw pin, low = pressed
//   activity_button in  : raw pin, low = pressed
//   logic0          out : one-cycle pulse on an accepted logic-0 press
//   logic1          out : one-cycle pulse on an accepted logic-1 press
//   activity        out : one-cycle pulse on release after a short press
//   activity_reset  out : one-cycle pulse when a hold reaches LONG_PRESS_CYCLES
//   held[2:0]       out : debounced pressed levels {activity, logic1, logic0}
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       logic_0_button,
  input  logic       logic_1_button,
  input  logic       activity_button,
  output logic       logic0,
  output logic       logic1,
  output logic       activity,
  output logic       activity_reset,
  output logic [2:0] held
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DCW-1:0] DEB_MAX   = DCW'(DEBOUNCE_CYCLES);
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(LONG_PRESS_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(LONG_PRESS_CYCLES - 1);

  // Bit positions inside the per-button vectors.
  localparam int BTN_L0  = 0;
  localparam int BTN_L1  = 1;
  localparam int BTN_ACT = 2;

  // Activity FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]           raw_n;
  logic [2:0]           pressed;

  logic [2:0]           sync1_q,      sync1_d;
  logic [2:0]           sync2_q,      sync2_d;
  logic [2:0]           stable_q,     stable_d;
  logic [2:0]           stable_dly_q, stable_dly_d;
  logic [2:0]           armed_q,      armed_d;
  logic [2:0][DCW-1:0]  deb_cnt_q,    deb_cnt_d;

  logic [2:0]           rise;
  logic                 act_fall;

  logic [1:0]           state_q,      state_d;
  logic [HCW-1:0]       hold_cnt_q,   hold_cnt_d;

  logic                 logic0_q,         logic0_d;
  logic                 logic1_q,         logic1_d;
  logic                 activity_q,       activity_d;
  logic                 activity_reset_q, activity_reset_d;

  assign raw_n = {activity_button, logic_1_button, logic_0_button};

  // The synchroniser holds the raw (active-low) level. Inversion happens on
  // its output. A cleared synchroniser therefore reads as "pressed". That is
  // harmless because arming also requires a released synchronised level.
  assign pressed = ~sync2_q;

  // ---------------------------------------------------------------------------
  // Synchroniser, debouncer and arming
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d   = raw_n;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    armed_d   = armed_q;

    for (int i = 0; i < 3; i++) begin
      // Any cycle that agrees with the accepted level restarts the count. A
      // level is accepted only after the count has sat at DEB_MAX with the
      // disagreement still present. Glitches shorter than that are dropped.
      if (pressed[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        stable_d[i]  = pressed[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end

      // A button arms only once it is seen released, both debounced and at
      // the synchroniser. A button held through reset stays disarmed until
      // it is let go.
      armed_d[i] = armed_q[i] | (~stable_q[i] & ~pressed[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection and logic-button pulses
  // ---------------------------------------------------------------------------
  always_comb begin
    stable_dly_d = stable_q;

    rise     = stable_q & ~stable_dly_q & armed_q;
    act_fall = ~stable_q[BTN_ACT] & stable_dly_q[BTN_ACT];

    // Checking the other button's level also suppresses same-cycle presses.
    // Both levels are already 1 when the rising edges are seen.
    logic0_d = rise[BTN_L0] & ~stable_q[BTN_L1];
    logic1_d = rise[BTN_L1] & ~stable_q[BTN_L0];
  end

  // ---------------------------------------------------------------------------
  // Activity FSM: short press -> activity on release, long hold -> reset
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    hold_cnt_d       = hold_cnt_q;
    activity_d       = 1'b0;
    activity_reset_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise[BTN_ACT]) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end

      ST_HOLD: begin
        // Saturating count, never wraps even if the hold lasts forever.
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        // The threshold is tested ahead of the release, so a release seen on
        // the very cycle the count reaches the limit still counts as long.
        if (hold_cnt_q == HOLD_LAST) begin
          activity_reset_d = 1'b1;
          state_d          = ST_LONG;
        end else if (act_fall) begin
          activity_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_LONG: begin
        if (act_fall) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      stable_q         <= '0;
      stable_dly_q     <= '0;
      armed_q          <= '0;
      deb_cnt_q        <= '0;
      state_q          <= ST_IDLE;
      hold_cnt_q       <= '0;
      logic0_q         <= 1'b0;
      logic1_q         <= 1'b0;
      activity_q       <= 1'b0;
      activity_reset_q <= 1'b0;
    end else begin
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      stable_q         <= stable_d;
      stable_dly_q     <= stable_dly_d;
      armed_q          <= armed_d;
      deb_cnt_q        <= deb_cnt_d;
      state_q          <= state_d;
      hold_cnt_q       <= hold_cnt_d;
      logic0_q         <= logic0_d;
      logic1_q         <= logic1_d;
      activity_q       <= activity_d;
      activity_reset_q <= activity_reset_d;
    end
  end

  assign logic0         = logic0_q;
  assign logic1         = logic1_q;
  assign activity       = activity_q;
  assign activity_reset = activity_reset_q;
  assign held           = stable_q;

endmodule
